// File: rtl/channel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : channel_fifo
//  Description : Synchronous valid/ready FIFO buffering the merged instruction
//                stream from the round-robin arbiter towards the core input.
//                Absorbs back-pressure bursts; output is first-word-fall-
//                through (head word visible without a read strobe).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: CHANNEL_FIFO_BYPASS_EN
//    When defined, an empty FIFO forwards in_valid/in_data straight to
//    out_valid/out_data in the same cycle (zero latency). This introduces a
//    combinational in->out path. When undefined, minimum latency is 1 cycle
//    and there is no combinational in->out path.
// ----------------------------------------------------------------------------
//  Parameters
//    DWIDTH    : payload width in bits
//    DEPTH     : number of entries, power of two, >= 2
//  Ports
//    clk       : clock, all state updates on rising edge
//    rst       : synchronous active-high reset
//    in_valid  : upstream word valid
//    in_data   : upstream word
//    in_ready  : FIFO can accept a word this cycle (registered state + rst only)
//    out_valid : word available to downstream
//    out_data  : head word (zero when out_valid is low)
//    out_ready : downstream accepts head word
//    count     : current occupancy, 0..DEPTH
//    full      : count == DEPTH
//    empty     : count == 0
// ============================================================================
module channel_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0]   c_full_cnt = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_ptr_one  = AW'(1);
  localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q,    cnt_d;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_out_valid;
  logic [DWIDTH-1:0] w_out_data;

  // --------------------------------------------------------------------------
  // Status flags: derived purely from the occupancy register
  // --------------------------------------------------------------------------
  assign w_full  = (cnt_q == c_full_cnt);
  assign w_empty = (cnt_q == '0);

  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = cnt_q;

  // Acceptance never looks at out_ready: a pop while full does not open the
  // input in the same cycle, which keeps in_ready free of a ready->ready path.
  assign in_ready = !w_full && !rst;

  // --------------------------------------------------------------------------
  // Output presentation
  // --------------------------------------------------------------------------
`ifdef CHANNEL_FIFO_BYPASS_EN
  logic w_fwd;

  // Forwarding is gated by !rst through the same condition as in_ready, so a
  // word offered during reset is neither stored nor presented.
  assign w_fwd = w_empty && in_valid && !rst;

  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = '0;
    if (!w_empty) begin
      w_out_valid = 1'b1;
      w_out_data  = mem_q[rd_ptr_q];
    end else if (w_fwd) begin
      w_out_valid = 1'b1;
      w_out_data  = in_data;
    end
  end
`else
  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = '0;
    if (!w_empty) begin
      w_out_valid = 1'b1;
      w_out_data  = mem_q[rd_ptr_q];
    end
  end
`endif

  assign out_valid = w_out_valid;
  assign out_data  = w_out_data;

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  // With bypass, an empty FIFO that forwards and gets out_ready performs a
  // push and a pop together: the word is written and immediately consumed,
  // both pointers advance and the occupancy stays zero.
  assign w_push = in_valid && in_ready;
  assign w_pop  = w_out_valid && out_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    // Pointers roll over naturally at AW bits (DEPTH is a power of two).
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_ptr_one;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end

    unique case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + c_cnt_one;
      2'b01:   cnt_d = cnt_q - c_cnt_one;
      default: cnt_d = cnt_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after being written,
  // and out_data is forced to zero whenever nothing valid is presented.
  // w_push already includes !rst, so reset-cycle writes are dropped.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_channel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_channel_fifo
//  Description : Directed self-checking bench for channel_fifo (DEPTH=8,
//                DWIDTH=16). Inputs change 1 ns after the rising edge and
//                outputs are observed 2 ns after the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_fifo;

  localparam int DW = 16;
  localparam int DP = 8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [3:0]    count;
  logic          full;
  logic          empty;

  int total;
  int bad;

  channel_fifo #(
    .DWIDTH (DW),
    .DEPTH  (DP)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs may be changed right after this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
    tick(); tick(); settle();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_during_rst got=%b want=0", in_ready); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags empty=%b full=%b want empty=1 full=0", empty, full); end
    total++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin bad++; $display("FAIL reset_out got valid=%b data=%h want 0/0000", out_valid, out_data); end
    rst = 1'b0; in_valid = 1'b0; settle();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_after got=%b want=1", in_ready); end
    tick(); settle();
    total++; if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 16'h0) begin bad++; $display("FAIL reset_idle got count=%0d valid=%b data=%h want 0/0/0000", count, out_valid, out_data); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 1; i <= DP; i++) begin
      in_valid = 1'b1; in_data = DW'(i); settle();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_in_ready word=%0d got=%b want=1", i, in_ready); end
      tick();
    end
    in_valid = 1'b1; in_data = 16'h0009; settle();
    total++; if (count !== 4'd8 || full !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL fill_full got count=%0d full=%b in_ready=%b want 8/1/0", count, full, in_ready); end
    tick(); in_valid = 1'b0; settle();
    total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_ninth_rejected got count=%0d want=8", count); end
    out_ready = 1'b1;
    for (int i = 1; i <= DP; i++) begin
      settle();
      total++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin bad++; $display("FAIL drain_word idx=%0d got valid=%b data=%h want 1/%h", i, out_valid, out_data, DW'(i)); end
      tick();
    end
    out_ready = 1'b0; settle();
    total++; if (empty !== 1'b1 || out_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL drain_empty got empty=%b valid=%b count=%0d want 1/0/0", empty, out_valid, count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stream();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'h0100 + DW'(i); tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = 16'h0103 + DW'(k); settle();
      total++; if (count !== 4'd3 || out_data !== 16'h0100 + DW'(k) || out_valid !== 1'b1) begin bad++; $display("FAIL stream cyc=%0d got count=%0d data=%h want 3/%h", k, count, out_data, 16'h0100 + DW'(k)); end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 20; k < 23; k++) begin
      settle();
      total++; if (out_valid !== 1'b1 || out_data !== 16'h0100 + DW'(k)) begin bad++; $display("FAIL stream_tail idx=%0d got %h want %h", k, out_data, 16'h0100 + DW'(k)); end
      tick();
    end
    out_ready = 1'b0; settle();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL stream_end_empty got=%b want=1", empty); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < DP; i++) begin
      in_valid = 1'b1; in_data = 16'h0200 + DW'(i); tick();
    end
    in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 1'b1; settle();
    total++; if (in_ready !== 1'b0 || out_data !== 16'h0200) begin bad++; $display("FAIL fullpop_same_cycle got in_ready=%b data=%h want 0/0200", in_ready, out_data); end
    tick(); in_valid = 1'b0; out_ready = 1'b0; settle();
    total++; if (count !== 4'd7 || in_ready !== 1'b1) begin bad++; $display("FAIL fullpop_next got count=%0d in_ready=%b want 7/1", count, in_ready); end
    out_ready = 1'b1;
    for (int i = 1; i < DP; i++) begin
      settle();
      total++; if (out_data !== 16'h0200 + DW'(i)) begin bad++; $display("FAIL fullpop_drain idx=%0d got %h want %h", i, out_data, 16'h0200 + DW'(i)); end
      tick();
    end
    out_ready = 1'b0; settle();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fullpop_end_empty got=%b want=1 (extra word stored?)", empty); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [DW-1:0] mq[$];
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_ready;
    logic          held;
    logic [DW-1:0] held_data;
    logic          do_push;
    logic          do_pop;
    held = 1'b0; held_data = '0;
    for (int k = 0; k < 48; k++) begin
      out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'h3000 + DW'(k);
      settle();
      exp_ready = (mq.size() < DP);
      exp_valid = (mq.size() > 0);
      exp_data  = (mq.size() > 0) ? mq[0] : '0;
`ifdef CHANNEL_FIFO_BYPASS_EN
      if (mq.size() == 0 && in_valid) begin
        exp_valid = 1'b1;
        exp_data  = in_data;
      end
`endif
      total++; if (out_valid !== exp_valid || out_data !== exp_data || in_ready !== exp_ready || count !== 4'(mq.size())) begin
        bad++; $display("FAIL bp_cycle cyc=%0d got valid=%b data=%h rdy=%b cnt=%0d want %b/%h/%b/%0d", k, out_valid, out_data, in_ready, count, exp_valid, exp_data, exp_ready, mq.size());
      end
      if (held) begin
        total++; if (out_valid !== 1'b1 || out_data !== held_data) begin bad++; $display("FAIL bp_stable cyc=%0d got valid=%b data=%h want 1/%h", k, out_valid, out_data, held_data); end
      end
      held      = exp_valid && !out_ready;
      held_data = exp_data;
      do_push   = in_valid && exp_ready;
      do_pop    = exp_valid && out_ready;
      if (do_push) mq.push_back(in_data);
      if (do_pop)  void'(mq.pop_front());
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 2 * DP && mq.size() > 0; k++) begin
      settle();
      total++; if (out_valid !== 1'b1 || out_data !== mq[0]) begin bad++; $display("FAIL bp_drain idx=%0d got valid=%b data=%h want 1/%h", k, out_valid, out_data, mq[0]); end
      void'(mq.pop_front());
      tick();
    end
    out_ready = 1'b0; settle();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL bp_end_empty got=%b want=1", empty); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_empty_forward();
    in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1; settle();
`ifdef CHANNEL_FIFO_BYPASS_EN
    total++; if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin bad++; $display("FAIL bypass_same_cycle got valid=%b data=%h want 1/beef", out_valid, out_data); end
    tick(); in_valid = 1'b0; settle();
    total++; if (count !== 4'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL bypass_after got count=%0d valid=%b want 0/0", count, out_valid); end
`else
    total++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin bad++; $display("FAIL nobypass_same_cycle got valid=%b data=%h want 0/0000", out_valid, out_data); end
    tick(); in_valid = 1'b0; settle();
    total++; if (out_valid !== 1'b1 || out_data !== 16'hBEEF || count !== 4'd1) begin bad++; $display("FAIL nobypass_next got valid=%b data=%h count=%0d want 1/beef/1", out_valid, out_data, count); end
    tick(); settle();
    total++; if (empty !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL nobypass_popped got empty=%b valid=%b want 1/0", empty, out_valid); end
`endif
    out_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'h0500 + DW'(i); tick();
    end
    in_valid = 1'b0; settle();
    total++; if (count !== 4'd5) begin bad++; $display("FAIL rstmid_pre got count=%0d want=5", count); end
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h0A0A; tick(); settle();
    total++; if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 16'h0) begin bad++; $display("FAIL rstmid_cleared got count=%0d valid=%b data=%h want 0/0/0000", count, out_valid, out_data); end
    rst = 1'b0; in_valid = 1'b0; tick(); settle();
    total++; if (empty !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_post got empty=%b in_ready=%b valid=%b want 1/1/0", empty, in_ready, out_valid); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_full_pop();
    test_backpressure();
    test_empty_forward();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/channel_fifo.md
# channel_fifo

Synchronous valid/ready FIFO that buffers the merged instruction stream produced by the two-input round-robin arbiter and feeds the downstream core input. It absorbs back-pressure bursts so the arbiter can keep granting while the consumer stalls. Output is first-word-fall-through. An optional compile-time bypass gives zero-latency forwarding when the FIFO is empty.

## Interface
Parameters:
- DWIDTH, 16, payload width in bits
- DEPTH, 8, number of entries; power of two, ≥ 2
- AW (localparam), $clog2(DEPTH), pointer width

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream word valid
- in_data  in  DWIDTH  upstream word
- in_ready  out  1  FIFO can accept a word this cycle
- out_valid  out  1  word available to downstream
- out_data  out  DWIDTH  head word
- out_ready  in  1  downstream accepts head word
- count  out  AW+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage: DEPTH×DWIDTH array, write pointer wr_ptr and read pointer rd_ptr (AW bits each), occupancy register cnt (AW+1 bits).
- Push = in_valid && in_ready: mem[wr_ptr] <= in_data; wr_ptr increments.
- Pop = out_valid && out_ready: rd_ptr increments.
- Pointers wrap from DEPTH-1 to 0 (natural AW-bit rollover).
- cnt: +1 on push only, −1 on pop only, unchanged on both or neither.
- in_ready = !full && !rst. It depends only on registered state, with no combinational path from out_ready. When full, a same-cycle pop does not open in_ready.
- Without bypass:
  - out_valid = !empty.
  - out_data = mem[rd_ptr] when out_valid, else all zeros.
- full = (cnt == DEPTH); empty = (cnt == 0); count = cnt. All three are derived from registers.
- Stability: while out_valid && !out_ready, out_valid stays 1 and out_data stays constant until the pop.
- Reset mid-operation discards all contents. Pointers and cnt return to 0. Writes in the reset cycle are ignored.
- Overflow and underflow are impossible by construction; no error flags.

## Timing
- Reset values (the cycle after rst is sampled high, and while rst is held):
  - count=0, empty=1, full=0
  - out_valid=0, out_data=0
  - in_ready=0 while rst is high, 1 in the first cycle after rst deasserts
- Latency, no bypass: a word pushed in cycle N appears on out_valid/out_data in cycle N+1.
- Throughput: one push and one pop per cycle sustained. Simultaneous push and pop at any 0 < cnt < DEPTH leaves cnt unchanged.
- Full boundary: cnt=DEPTH gives in_ready=0. A pop in cycle N gives in_ready=1 in cycle N+1.
- Empty boundary: a pop of the last word in cycle N gives out_valid=0 in N+1, unless a push also occurred in N.

## Configuration
- Macro CHANNEL_FIFO_BYPASS_EN.
- Defined, when empty:
  - out_valid = in_valid and out_data = in_data (combinational forwarding).
  - If out_ready=1, push and pop happen in the same cycle: both pointers advance, cnt stays 0, the word leaves with zero latency.
  - If out_ready=0, the word is written normally (cnt→1). Next cycle it is presented from memory with identical data, so stability holds.
  - Adds a combinational in→out path.
- Undefined: behaviour exactly as above, with 1-cycle minimum latency and no in→out combinational path.

## Test plan
- Reset, then idle: count=0, empty=1, full=0, out_valid=0, out_data=0, in_ready=1 from the first post-reset cycle.
- DEPTH=8, out_ready=0, push 0x0001..0x0008:
  - count reaches 8, full=1, in_ready=0, 9th word not accepted.
  - Then out_ready=1 pops 0x0001..0x0008 in order, one per cycle, ending empty=1.
- Stream with in_valid=out_ready=1 for 20 cycles from count=3: count stays 3. Output order equals input order across ≥2 pointer wraps.
- Full plus out_ready=1 and in_valid=1 in the same cycle: no push, count 8→7, in_ready=1 next cycle.
- Back-pressure: out_ready toggles 1,0,0,1 with random in_valid. out_data is held constant during every out_valid && !out_ready span, and there is no loss or duplication, checked by scoreboard.
- Empty FIFO, in_valid=1, in_data=0xBEEF, out_ready=1:
  - With CHANNEL_FIFO_BYPASS_EN: out_valid=1 and out_data=0xBEEF the same cycle, count stays 0.
  - Without it: out_valid=1 with 0xBEEF the next cycle.
  - Also assert rst mid-stream at count=5: next cycle count=0, out_valid=0.
